mem_lsu: RTL and testbench

Load/store initiator for the byte-addressed, little-endian 32-bit data RAM: it accepts one byte, halfword or word access from the core and drives the RAM's read port (addr_r/rdata) and write port (addr_w/wdata/we). The RAM only writes whole 32-bit words, so byte and halfword stores are done as read-modify-write on the containing aligned word. Loads return sign- or zero-extended data. Misaligned and out-of-range accesses are rejected without touching memory.

---
 rtl/mem_lsu_if.sv | 24 ++
 rtl/mem_lsu.sv | 139 +++++++++++++
 tb/tb_mem_lsu.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lsu_if.sv
// Core-side request/response bundle of the load/store unit.
// The core drives the request; the LSU returns status and load data.
interface mem_lsu_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, uns, addr, wdata,
    input  busy, done, err, rdata
  );

  modport slave (
    input  req, wr, size, uns, addr, wdata,
    output busy, done, err, rdata
  );
endinterface

// File: rtl/mem_lsu.sv
// Load/store initiator for a word-wide little-endian RAM; sub-word stores
// are done as read-modify-write on the containing aligned word.
module mem_lsu #(
  parameter int unsigned ADDR_BITS = 12
) (
  input  logic        m_clock,
  input  logic        p_reset,
  mem_lsu_if.slave    core,
  output logic [31:0] mem_addr_r,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr_w,
  output logic [31:0] mem_wdata,
  output logic        mem_we
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t      state;
  logic        wr_q;
  logic        uns_q;
  logic [1:0]  size_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;
  logic [31:0] a_q;
  logic [31:0] wword_q;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        reject;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic [31:0] merged;

  always_comb begin
    reject = 1'b0;
    case (core.size)
      2'b11:   reject = 1'b1;
      2'b01:   reject = core.addr[0];
      2'b10:   reject = (core.addr[1:0] != 2'b00);
      default: reject = 1'b0;
    endcase
    if ((core.addr >> ADDR_BITS) != '0)
      reject = 1'b1;
  end

  always_comb begin
    case (lane_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   ld_val = uns_q ? {24'h0, ld_byte} : {{24{ld_byte[7]}}, ld_byte};
      2'b01:   ld_val = uns_q ? {16'h0, ld_half} : {{16{ld_half[15]}}, ld_half};
      default: ld_val = mem_rdata;
    endcase
  end

  // Only sub-word stores pass through RD, so size_q is byte or half here.
  always_comb begin
    merged = mem_rdata;
    if (size_q == 2'b00) begin
      case (lane_q)
        2'd0:    merged[7:0]   = wdata_q[7:0];
        2'd1:    merged[15:8]  = wdata_q[7:0];
        2'd2:    merged[23:16] = wdata_q[7:0];
        default: merged[31:24] = wdata_q[7:0];
      endcase
    end else if (lane_q[1]) begin
      merged[31:16] = wdata_q;
    end else begin
      merged[15:0] = wdata_q;
    end
  end

  always_ff @(posedge m_clock or negedge p_reset) begin
    if (!p_reset) begin
      state   <= IDLE;
      wr_q    <= 1'b0;
      uns_q   <= 1'b0;
      size_q  <= '0;
      lane_q  <= '0;
      wdata_q <= '0;
      a_q     <= '0;
      wword_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (core.req) begin
            wr_q    <= core.wr;
            uns_q   <= core.uns;
            size_q  <= core.size;
            lane_q  <= core.addr[1:0];
            wdata_q <= core.wdata[15:0];
            a_q     <= {core.addr[31:2], 2'b00};
            if (reject) begin
              err_q <= 1'b1;
              state <= DONE;
            end else if (core.wr && core.size == 2'b10) begin
              wword_q <= core.wdata;
              state   <= WR;
            end else begin
              state <= RD;
            end
          end
        end
        RD: begin
          if (wr_q) begin
            wword_q <= merged;
            state   <= WR;
          end else begin
            rdata_q <= ld_val;
            state   <= DONE;
          end
        end
        WR: state <= DONE;
        default: begin
          err_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign core.busy  = (state != IDLE);
  assign core.done  = (state == DONE);
  assign core.err   = err_q;
  assign core.rdata = rdata_q;
  assign mem_addr_r = a_q;
  assign mem_addr_w = a_q;
  assign mem_wdata  = wword_q;
  assign mem_we     = (state == WR);

endmodule

// File: tb/tb_mem_lsu.sv
// Directed scoreboard bench for mem_lsu with a behavioural word RAM.
module tb_mem_lsu;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_lsu_if bus();
  logic [31:0] mem_addr_r, mem_rdata, mem_addr_w, mem_wdata;
  logic        mem_we;

  mem_lsu #(.ADDR_BITS(12)) dut (
    .m_clock   (clk),
    .p_reset   (rst_n),
    .core      (bus.slave),
    .mem_addr_r(mem_addr_r),
    .mem_rdata (mem_rdata),
    .mem_addr_w(mem_addr_w),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we)
  );

  logic [31:0] ram [0:1023];
  logic        pre_we = 1'b0;
  logic [31:0] pre_addr = '0;
  logic [31:0] pre_data = '0;

  assign mem_rdata = ram[mem_addr_r[11:2]];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr_w[11:2]] <= mem_wdata;
    else if (pre_we) ram[pre_addr[11:2]] <= pre_data;
  end

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    string       name;
    logic        err;
    logic [31:0] rdata;
    int unsigned cyc;
  } exp_t;
  exp_t sbq[$];

  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned we_cnt = 0;
  int unsigned we_cyc = 0;
  logic [31:0] we_data = '0;
  logic [31:0] last_rd = '0;

  function automatic void chk(string name, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  // Monitor: records writes and pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    exp_t e;
    if (mem_we) begin
      we_cnt  <= we_cnt + 1;
      we_cyc  <= cyc;
      we_data <= mem_wdata;
    end
    if (rst_n && bus.done) begin
      if (sbq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_done: got done=1 at cycle %0d expected none", cyc);
      end else begin
        e = sbq.pop_front();
        chk({e.name, "_done_cyc"}, cyc, e.cyc);
        chk({e.name, "_err"}, {31'h0, bus.err}, {31'h0, e.err});
        chk({e.name, "_rdata"}, bus.rdata, e.rdata);
      end
    end
  end

  task automatic preload(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    pre_we = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  task automatic issue(input string name, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] a, input logic [31:0] d,
                       input logic e_err, input logic [31:0] e_rd,
                       input int unsigned lat, input int we_off, input logic [31:0] e_wd);
    int unsigned n, wc0;
    bit seen;
    logic [31:0] exp_rd;
    @(negedge clk);
    bus.req = 1'b1; bus.wr = w; bus.size = sz; bus.uns = u; bus.addr = a; bus.wdata = d;
    n = cyc;
    wc0 = we_cnt;
    exp_rd = (!w && !e_err) ? e_rd : last_rd;
    last_rd = exp_rd;
    sbq.push_back('{name, e_err, exp_rd, n + lat});
    @(negedge clk);
    bus.req = 1'b0;
    seen = bus.done;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s_timeout: got no done expected done within 9 cycles", name);
    end
    chk({name, "_we_count"}, we_cnt - wc0, (we_off >= 0) ? 32'd1 : 32'd0);
    if (we_off >= 0) begin
      chk({name, "_we_cyc"}, we_cyc, n + we_off);
      chk({name, "_mem_wdata"}, we_data, e_wd);
    end
  endtask

  task automatic ld(input string name, input logic [1:0] sz, input logic u,
                    input logic [31:0] a, input logic [31:0] e);
    issue(name, 1'b0, sz, u, a, '0, 1'b0, e, 2, -1, '0);
  endtask

  task automatic st(input string name, input logic [1:0] sz, input logic [31:0] a,
                    input logic [31:0] d, input logic [31:0] e_wd);
    issue(name, 1'b1, sz, 1'b0, a, d, 1'b0, '0, (sz == 2'b10) ? 2 : 3,
          (sz == 2'b10) ? 1 : 2, e_wd);
  endtask

  task automatic rej(input string name, input logic w, input logic [1:0] sz, input logic [31:0] a);
    issue(name, w, sz, 1'b0, a, 32'hA5A5A5A5, 1'b1, '0, 1, -1, '0);
  endtask

  initial begin
    int unsigned n, wc0;
    bus.req = 1'b0; bus.wr = 1'b0; bus.size = '0; bus.uns = 1'b0;
    bus.addr = '0; bus.wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_done", {31'h0, bus.done}, 32'h0);
    chk("rst_err", {31'h0, bus.err}, 32'h0);
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_we", {31'h0, mem_we}, 32'h0);
    chk("rst_addr_r", mem_addr_r, 32'h0);
    chk("rst_addr_w", mem_addr_w, 32'h0);
    chk("rst_wdata", mem_wdata, 32'h0);
    rst_n = 1'b1;

    preload(32'h100, 32'h8899AABB);
    preload(32'h104, 32'h01234567);
    preload(32'h200, 32'h0);
    preload(32'h300, 32'h0);
    preload(32'hFFC, 32'hCAFEF00D);

    ld("lb_101", 2'b00, 1'b0, 32'h101, 32'hFFFFFFAA);
    ld("lbu_101", 2'b00, 1'b1, 32'h101, 32'h000000AA);
    ld("lh_102", 2'b01, 1'b0, 32'h102, 32'hFFFF8899);
    ld("lhu_102", 2'b01, 1'b1, 32'h102, 32'h00008899);
    ld("lw_100", 2'b10, 1'b0, 32'h100, 32'h8899AABB);

    st("sb_103", 2'b00, 32'h103, 32'h00000011, 32'h1199AABB);
    ld("lw_100_raw", 2'b10, 1'b0, 32'h100, 32'h1199AABB);
    ld("lw_104", 2'b10, 1'b0, 32'h104, 32'h01234567);
    chk("ram_104", ram[65], 32'h01234567);

    st("sw_200", 2'b10, 32'h200, 32'hDEADBEEF, 32'hDEADBEEF);
    st("sh_202", 2'b01, 32'h202, 32'h00001234, 32'h1234BEEF);
    ld("lw_200", 2'b10, 1'b0, 32'h200, 32'h1234BEEF);
    st("sb_200", 2'b00, 32'h200, 32'hFFFFFF77, 32'h1234BE77);
    ld("lb_200", 2'b00, 1'b0, 32'h200, 32'h00000077);
    ld("lh_200", 2'b01, 1'b0, 32'h200, 32'hFFFFBE77);
    ld("lb_203", 2'b00, 1'b0, 32'h203, 32'h00000012);
    ld("lbu_202", 2'b00, 1'b1, 32'h202, 32'h00000034);
    ld("lw_ffc", 2'b10, 1'b0, 32'hFFC, 32'hCAFEF00D);
    ld("lbu_fff", 2'b00, 1'b1, 32'hFFF, 32'h000000CA);

    rej("rej_lh_101", 1'b0, 2'b01, 32'h101);
    rej("rej_sw_102", 1'b1, 2'b10, 32'h102);
    rej("rej_lw_1000", 1'b0, 2'b10, 32'h1000);
    rej("rej_size11", 1'b0, 2'b11, 32'h100);
    rej("rej_sb_1000", 1'b1, 2'b00, 32'h1000);
    chk("ram_100_after_rej", ram[64], 32'h1199AABB);

    // Reset asserted in the WR cycle of a byte store.
    wc0 = we_cnt;
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b1; bus.size = 2'b00; bus.uns = 1'b0;
    bus.addr = 32'h101; bus.wdata = 32'h00000055;
    @(negedge clk);
    bus.req = 1'b0;
    @(posedge clk);
    #1;
    chk("rstwr_we_before", {31'h0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rstwr_we", {31'h0, mem_we}, 32'h0);
    chk("rstwr_busy", {31'h0, bus.busy}, 32'h0);
    chk("rstwr_done", {31'h0, bus.done}, 32'h0);
    chk("rstwr_rdata", bus.rdata, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
    repeat (3) @(negedge clk);
    chk("rstwr_ram", ram[64], 32'h1199AABB);
    chk("rstwr_we_count", we_cnt - wc0, 32'h0);
    ld("lw_100_post_rst", 2'b10, 1'b0, 32'h100, 32'h1199AABB);

    // A req pulse during RD of a load must be ignored.
    wc0 = we_cnt;
    @(negedge clk);
    bus.req = 1'b1; bus.wr = 1'b0; bus.size = 2'b10; bus.uns = 1'b0;
    bus.addr = 32'h104; bus.wdata = '0;
    n = cyc;
    sbq.push_back('{"ign_lw_104", 1'b0, 32'h01234567, n + 2});
    last_rd = 32'h01234567;
    @(negedge clk);
    bus.wr = 1'b1; bus.addr = 32'h300; bus.wdata = 32'hBAD0BAD0;
    @(negedge clk);
    bus.req = 1'b0;
    repeat (5) @(negedge clk);
    chk("ign_ram_300", ram[192], 32'h0);
    chk("ign_we_count", we_cnt - wc0, 32'h0);
    chk("ign_busy", {31'h0, bus.busy}, 32'h0);

    chk("sb_empty", sbq.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
